// File: rtl/cve2_rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port, with a registered output stage.
// Define CVE2_RF_WB_SCOREBOARD_EN to build the pending-write (RAW hazard) busy scoreboard.
module cve2_rf_wb_arbiter #(
  parameter int unsigned NumReq    = 3,
  parameter int unsigned DataWidth = 32,
  parameter bit          RV32E     = 1'b0
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumReq-1:0]                   req_valid_i,
  input  logic [NumReq-1:0][4:0]              req_addr_i,
  input  logic [NumReq-1:0][DataWidth-1:0]    req_data_i,
  output logic [NumReq-1:0]                   req_ready_o,
  output logic [4:0]                          rf_waddr_o,
  output logic [DataWidth-1:0]                rf_wdata_o,
  output logic                                rf_we_o,
  output logic                                illegal_addr_o,
  input  logic                                sb_set_i,
  input  logic [4:0]                          sb_set_addr_i,
  input  logic [4:0]                          sb_rs1_addr_i,
  input  logic [4:0]                          sb_rs2_addr_i,
  output logic                                sb_rs1_busy_o,
  output logic                                sb_rs2_busy_o,
  output logic                                sb_conflict_o
);

  localparam int unsigned PtrW = (NumReq > 2) ? 2 : 1;

  logic [PtrW-1:0]      ptr_q, ptr_d;
  logic [PtrW-1:0]      gnt_idx;
  logic [PtrW:0]        cand_sum;
  logic [NumReq-1:0]    gnt;
  logic                 hs;
  logic [4:0]           sel_addr;
  logic [DataWidth-1:0] sel_data;
  logic                 addr_oor;

  logic                 rf_we_q, rf_we_d;
  logic [4:0]           rf_waddr_q, rf_waddr_d;
  logic [DataWidth-1:0] rf_wdata_q, rf_wdata_d;
  logic                 illegal_q, illegal_d;

  // Walk the requesters starting just after the last winner; the first valid one is granted.
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    cand_sum = '0;
    for (int unsigned k = 1; k <= NumReq; k++) begin
      cand_sum = {1'b0, ptr_q} + (PtrW+1)'(k);
      if (cand_sum >= (PtrW+1)'(NumReq)) begin
        cand_sum = cand_sum - (PtrW+1)'(NumReq);
      end
      if ((gnt == '0) && req_valid_i[cand_sum[PtrW-1:0]]) begin
        gnt[cand_sum[PtrW-1:0]] = 1'b1;
        gnt_idx                 = cand_sum[PtrW-1:0];
      end
    end
  end

  assign hs          = |gnt;
  assign req_ready_o = gnt;
  assign sel_addr    = req_addr_i[gnt_idx];
  assign sel_data    = req_data_i[gnt_idx];
  assign addr_oor    = RV32E && sel_addr[4];

  always_comb begin
    ptr_d      = hs ? gnt_idx : ptr_q;
    rf_we_d    = hs && (sel_addr != 5'd0) && !addr_oor;
    illegal_d  = hs && addr_oor;
    rf_waddr_d = rf_we_d ? sel_addr : rf_waddr_q;
    rf_wdata_d = rf_we_d ? sel_data : rf_wdata_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= PtrW'(NumReq - 1);
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      illegal_q  <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      illegal_q  <= illegal_d;
    end
  end

  assign rf_we_o        = rf_we_q;
  assign rf_waddr_o     = rf_waddr_q;
  assign rf_wdata_o     = rf_wdata_q;
  assign illegal_addr_o = illegal_q;

`ifdef CVE2_RF_WB_SCOREBOARD_EN
  logic [31:1] busy_q;
  logic [31:0] busy_d;
  logic [31:0] busy_vec;
  logic        set_ok;
  logic        conflict_q, conflict_d;

  assign busy_vec = {busy_q, 1'b0};
  assign set_ok   = sb_set_i && (sb_set_addr_i != 5'd0) && !(RV32E && sb_set_addr_i[4]);

  // Clear is applied before set so a newly issued producer keeps the register busy.
  always_comb begin
    busy_d = busy_vec;
    if (rf_we_q) begin
      busy_d[rf_waddr_q] = 1'b0;
    end
    if (set_ok) begin
      busy_d[sb_set_addr_i] = 1'b1;
    end
    conflict_d = set_ok && busy_vec[sb_set_addr_i];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      busy_q     <= busy_d[31:1];
      conflict_q <= conflict_d;
    end
  end

  logic unused_busy_d0;
  assign unused_busy_d0 = busy_d[0];

  assign sb_rs1_busy_o = busy_vec[sb_rs1_addr_i];
  assign sb_rs2_busy_o = busy_vec[sb_rs2_addr_i];
  assign sb_conflict_o = conflict_q;
`else
  logic unused_sb_inputs;
  assign unused_sb_inputs = ^{sb_set_i, sb_set_addr_i, sb_rs1_addr_i, sb_rs2_addr_i};

  assign sb_rs1_busy_o = 1'b0;
  assign sb_rs2_busy_o = 1'b0;
  assign sb_conflict_o = 1'b0;
`endif

endmodule

// File: doc/cve2_rf_wb_arbiter.md
Name: cve2_rf_wb_arbiter

Overview:
- Shares the single register-file write port between NumReq writeback requesters: ALU/EX, LSU and X-interface result.
- Uses round-robin arbitration with valid/ready handshakes and drives the write port from a registered stage.
- Holds a pending-write scoreboard so the decoder can stall on RAW hazards against writes still in flight.
- Sits between the writeback sources and the flip-flop register file's waddr/wdata/we inputs.

Parameters:
- NumReq, 3, number of writeback requesters (2..4); index 0 has the highest initial priority.
- DataWidth, 32, register data width.
- RV32E, 0, 1 limits the register space to x0..x15; higher addresses are illegal.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  NumReq  requester i has a write pending
- req_addr_i  in  NumReq x 5  destination register per requester
- req_data_i  in  NumReq x DataWidth  write data per requester
- req_ready_o  out  NumReq  one-hot grant; a handshake occurs when valid and ready are both high
- rf_waddr_o  out  5  register-file write address (registered)
- rf_wdata_o  out  DataWidth  register-file write data (registered)
- rf_we_o  out  1  register-file write enable (registered)
- illegal_addr_o  out  1  one-cycle pulse: accepted request targeted an out-of-range register
- sb_set_i  in  1  an instruction with a destination register issued this cycle
- sb_set_addr_i  in  5  destination of the issued instruction
- sb_rs1_addr_i, sb_rs2_addr_i  in  5 each  source operands to check
- sb_rs1_busy_o, sb_rs2_busy_o  out  1 each  source has a pending write
- sb_conflict_o  out  1  one-cycle pulse: set issued to an already-busy register

Behaviour:
- Reset values:
  - rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0.
  - Round-robin pointer=NumReq-1, so requester 0 wins first.
  - All busy bits=0; illegal_addr_o=0; sb_conflict_o=0.
- Arbitration (combinational):
  - Search starts at pointer+1 mod NumReq; the first valid requester is granted.
  - req_ready_o is one-hot or all zero. It never depends on req_ready_o itself.
  - At most one grant per cycle.
- Pointer update:
  - On a handshake, the pointer loads the granted index.
  - With no handshake, the pointer holds.
  - A requester holding valid is served within NumReq cycles.
- Output stage (1-cycle latency):
  - A handshake in cycle N gives rf_we_o=1 with the captured addr/data in cycle N+1.
  - With no handshake, rf_we_o=0 next cycle and addr/data hold their previous values.
  - The register file never backpressures, so there is no stall path.
- x0 write:
  - Handshake completes (ready=1), but rf_we_o stays 0 next cycle. No error.
- RV32E=1 and addr[4]=1:
  - Handshake completes, write is dropped (rf_we_o=0), illegal_addr_o=1 the next cycle.
  - The busy bit is not touched.
- Scoreboard (busy[31:1]; busy[0] is constant 0):
  - Set: sb_set_i with addr!=0 (and in range when RV32E) sets busy[addr] at the clock edge.
  - Clear: busy[rf_waddr_o] clears at the edge ending a cycle where rf_we_o=1.
  - Set and clear on the same address in the same cycle: set wins, because a new producer issued.
  - Set on an already-busy register: sb_conflict_o pulses the next cycle; the bit stays set.
- Busy query:
  - sb_rsX_busy_o = busy[sb_rsX_addr_i], combinational.
  - No bypass: a register whose write is in the output stage this cycle still reads busy.
  - Address 0 always reads 0.
- Reset mid-operation:
  - Any in-flight captured write is discarded (rf_we_o=0) and all busy bits clear immediately.
  - Requesters must re-present their writes.

Optional Feature:
- CVE2_RF_WB_SCOREBOARD_EN defined: scoreboard built as described.
- Undefined:
  - No busy flops exist.
  - sb_rs1_busy_o, sb_rs2_busy_o and sb_conflict_o are tied 0.
  - sb_* inputs are unused, with explicit unused-signal sinks.
  - Arbitration and write port behaviour are identical.

Test Plan:
- Priority after reset: all three requesters valid from reset release.
  - Grants go 0,1,2,0 on consecutive cycles.
  - rf_we_o=1 each following cycle with the matching addr/data, e.g. req0 x5=0xDEADBEEF appears on the port one cycle after its grant.
- Fairness: req1 valid continuously; req0 re-asserts every cycle.
  - Grants alternate 0,1,0,1; req1 is never starved for more than 2 cycles.
- x0 and RV32E: req0 writes x0 with 0x1234, then x17 with RV32E=1.
  - Both handshakes complete with rf_we_o=0 on both.
  - illegal_addr_o pulses only for x17.
- Scoreboard: set x7 at cycle 0; rs1=x7 reads busy; req2 writes x7 at cycle 3.
  - busy stays 1 through cycle 4 (the rf_we_o cycle) and reads 0 from cycle 5.
- Set/clear collision: sb_set_i for x9 in the same cycle rf_we_o writes x9 → busy[9] remains 1.
  - A second set on x9 → sb_conflict_o pulses once.
- Reset mid-operation: assert rst_ni low while rf_we_o=1 and busy[3]=1.
  - Immediately rf_we_o=0 and busy[3]=0.
  - After release, requester 0 wins first.
